// File: rtl/instr_cache_refill_ctrl_if.sv
// Bundle of the fetch, set-array and L2 signals around the refill controller.
//   master : the refill controller's view (drives lookup/replace/stall/L2 request)
//   slave  : the surrounding environment's view (fetch stage, set array, L2)
interface instr_cache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  fetch_valid_i;
  logic                  cache_miss_i;
  logic                  flush_i;
  logic [ADDR_WIDTH-1:0] lookup_addr_o;
  logic                  rep_enable_o;
  logic [63:0]           rep_word_o;
  logic                  stall_o;
  logic                  l2_req_o;
  logic [ADDR_WIDTH-1:0] l2_addr_o;
  logic                  l2_ack_i;
  logic                  l2_data_valid_i;
  logic [63:0]           l2_data_i;
  logic                  refill_done_o;
  logic [31:0]           miss_count_o;

  modport master (
    input  pc_i, fetch_valid_i, cache_miss_i, flush_i,
    input  l2_ack_i, l2_data_valid_i, l2_data_i,
    output lookup_addr_o, rep_enable_o, rep_word_o, stall_o,
    output l2_req_o, l2_addr_o, refill_done_o, miss_count_o
  );

  modport slave (
    output pc_i, fetch_valid_i, cache_miss_i, flush_i,
    output l2_ack_i, l2_data_valid_i, l2_data_i,
    input  lookup_addr_o, rep_enable_o, rep_word_o, stall_o,
    input  l2_req_o, l2_addr_o, refill_done_o, miss_count_o
  );
endinterface

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache line refill sequencer.
// On a fetch miss it latches the block-aligned address, issues one L2 line
// request, streams the returned 64-bit beats into the set array through the
// replace-enable/replace-word pair, and stalls fetch until the line is in.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : instr_cache_refill_ctrl_if.master (fetch, set array, L2 signals)
//
// state  | meaning
// IDLE   | lookup follows pc_i, watching for a miss
// REQ    | L2 line request outstanding, waiting for ack (flush may abort)
// REFILL | passing L2 beats into the set array, flush ignored
// DONE   | one-cycle install pulse, set array does hit/LRU update
module instr_cache_refill_ctrl #(
  parameter int B          = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  instr_cache_refill_ctrl_if.master  bus
);
  localparam int NB  = B / 8;
  localparam int CW  = $clog2(NB);
  localparam int OFF = $clog2(B);

  typedef enum logic [1:0] {IDLE, REQ, REFILL, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           miss_q, miss_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    addr_d            = addr_q;
    miss_d            = miss_q;
    bus.lookup_addr_o = addr_q;
    bus.l2_addr_o     = addr_q;
    bus.rep_enable_o  = 1'b0;
    bus.rep_word_o    = '0;
    bus.stall_o       = 1'b1;
    bus.l2_req_o      = 1'b0;
    bus.refill_done_o = 1'b0;
    bus.miss_count_o  = miss_q;

    unique case (state_q)
      IDLE: begin
        bus.lookup_addr_o = bus.pc_i;
        bus.l2_addr_o     = '0;
        // Stall is raised even when a flush coincides; fetch is redirected anyway.
        bus.stall_o       = bus.fetch_valid_i && bus.cache_miss_i;
        if (bus.fetch_valid_i && bus.cache_miss_i && !bus.flush_i) begin
          addr_d  = {bus.pc_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          miss_d  = (miss_q == 32'hFFFF_FFFF) ? miss_q : miss_q + 32'd1;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.l2_req_o = 1'b1;
        // Ack wins over flush: once L2 accepted, the line must be consumed.
        if (bus.l2_ack_i)     state_d = REFILL;
        else if (bus.flush_i) state_d = IDLE;
      end
      REFILL: begin
        bus.rep_enable_o = bus.l2_data_valid_i;
        bus.rep_word_o   = bus.l2_data_i;
        if (bus.l2_data_valid_i) begin
          if (cnt_q == CW'(NB - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        bus.refill_done_o = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
module tb_instr_cache_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_cache_refill_ctrl_if #(.ADDR_WIDTH(32)) dif ();

  instr_cache_refill_ctrl #(.B(64), .ADDR_WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (dif)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] beat_q[$];
  logic [31:0] line_q[$];
  logic [31:0] exp_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.fetch_valid_i   = 1'b0;
    dif.cache_miss_i    = 1'b0;
    dif.flush_i         = 1'b0;
    dif.l2_ack_i        = 1'b0;
    dif.l2_data_valid_i = 1'b0;
    dif.l2_data_i       = '0;
  endtask

  // Monitor: every replace write and every install pulse is matched against
  // what the reference model has queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.rep_enable_o) begin
        total++;
        if (beat_q.size() == 0) begin
          bad++;
          $display("FAIL rep_unexpected: got word %0h expected no replace write", dif.rep_word_o);
        end else begin
          logic [63:0] e;
          e = beat_q.pop_front();
          if (dif.rep_word_o !== e) begin
            bad++;
            $display("FAIL rep_word: got %0h expected %0h", dif.rep_word_o, e);
          end
        end
      end
      if (dif.refill_done_o) begin
        total++;
        if (line_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got pulse expected none");
        end else begin
          logic [31:0] l;
          l = line_q.pop_front();
          if (dif.lookup_addr_o !== l) begin
            bad++;
            $display("FAIL done_line: got %0h expected %0h", dif.lookup_addr_o, l);
          end
        end
      end
    end
  end

  // One miss from IDLE. abort: flush in the first REQ cycle without ack.
  // rst_after >= 0: assert reset asynchronously after that many beats.
  task automatic run_miss(input logic [31:0] pc, input int ack_wait, input int gap_pct,
                          input bit flush_ack, input bit flush_refill, input bit abort,
                          input int rst_after, input logic [31:0] pc_ref);
    logic [31:0] line;
    int          n;
    int          cyc;
    bit          v;
    line = {pc[31:6], 6'b0};
    step();
    dif.pc_i          = pc;
    dif.fetch_valid_i = 1'b1;
    dif.cache_miss_i  = 1'b1;
    dif.flush_i       = 1'b0;
    @(negedge clk);
    chk("stall_on_miss", dif.stall_o, 1);
    chk("lookup_idle", dif.lookup_addr_o, pc);
    step();
    exp_miss          = (exp_miss == 32'hFFFF_FFFF) ? exp_miss : exp_miss + 1;
    dif.fetch_valid_i = 1'b0;
    dif.cache_miss_i  = 1'b0;
    dif.pc_i          = $urandom;
    dif.l2_data_valid_i = 1'($urandom);
    dif.l2_data_i     = {$urandom, $urandom};
    if (abort) begin
      dif.l2_ack_i = 1'b0;
      dif.flush_i  = 1'b1;
    end else begin
      dif.l2_ack_i = (ack_wait == 0);
      dif.flush_i  = (ack_wait == 0) && flush_ack;
    end
    @(negedge clk);
    chk("req_l2_req", dif.l2_req_o, 1);
    chk("req_l2_addr", dif.l2_addr_o, line);
    chk("req_lookup", dif.lookup_addr_o, line);
    chk("req_miss_count", dif.miss_count_o, exp_miss);
    chk("req_stall", dif.stall_o, 1);
    if (abort) begin
      step();
      dif.flush_i = 1'b0;
      dif.l2_ack_i = 1'b0;
      dif.l2_data_valid_i = 1'b1;
      @(negedge clk);
      chk("abort_l2_req", dif.l2_req_o, 0);
      chk("abort_stall", dif.stall_o, 0);
      chk("abort_lookup", dif.lookup_addr_o, dif.pc_i);
      idle_inputs();
      return;
    end
    for (int k = 1; k <= ack_wait; k++) begin
      step();
      dif.l2_ack_i = (k == ack_wait);
      dif.flush_i  = (k == ack_wait) && flush_ack;
      dif.l2_data_valid_i = 1'($urandom);
      @(negedge clk);
      chk("req_wait_l2_req", dif.l2_req_o, 1);
    end
    line_q.push_back(line);
    n   = 0;
    cyc = 0;
    while (n < 8 && cyc < 200) begin
      step();
      dif.l2_ack_i = 1'b0;
      dif.flush_i  = flush_refill ? 1'($urandom) : 1'b0;
      dif.pc_i     = (pc_ref != 0) ? pc_ref : $urandom;
      dif.l2_data_i = {$urandom, $urandom};
      if (n == rst_after) begin
        dif.l2_data_valid_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_stall", dif.stall_o, 0);
        chk("rst_l2_req", dif.l2_req_o, 0);
        chk("rst_rep_en", dif.rep_enable_o, 0);
        chk("rst_done", dif.refill_done_o, 0);
        chk("rst_miss_count", dif.miss_count_o, 0);
        chk("rst_lookup", dif.lookup_addr_o, dif.pc_i);
        beat_q.delete();
        line_q.delete();
        exp_miss = 0;
        idle_inputs();
        step();
        rst = 1'b0;
        return;
      end
      v = ($urandom_range(99) >= gap_pct);
      dif.l2_data_valid_i = v;
      if (v) beat_q.push_back(dif.l2_data_i);
      @(negedge clk);
      chk("refill_stall", dif.stall_o, 1);
      chk("refill_l2_req", dif.l2_req_o, 0);
      chk("refill_lookup", dif.lookup_addr_o, line);
      chk("refill_l2_addr", dif.l2_addr_o, line);
      chk("refill_no_done", dif.refill_done_o, 0);
      n += int'(v);
      cyc++;
    end
    if (n < 8) chk("beat_budget", n, 8);
    step();
    dif.flush_i = 1'b0;
    dif.l2_data_valid_i = 1'($urandom);
    dif.l2_data_i = {$urandom, $urandom};
    @(negedge clk);
    chk("done_pulse", dif.refill_done_o, 1);
    chk("done_stall", dif.stall_o, 1);
    chk("done_lookup", dif.lookup_addr_o, line);
    step();
    dif.l2_data_valid_i = 1'b1;
    dif.l2_data_i = {$urandom, $urandom} | 64'h1;
    @(negedge clk);
    chk("idle_stall", dif.stall_o, 0);
    chk("idle_done", dif.refill_done_o, 0);
    chk("idle_rep_word", dif.rep_word_o, 0);
    chk("idle_l2_req", dif.l2_req_o, 0);
    chk("idle_lookup", dif.lookup_addr_o, dif.pc_i);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    dif.pc_i = 32'hDEAD_BEEF;
    #3;
    chk("reset_stall", dif.stall_o, 0);
    chk("reset_l2_req", dif.l2_req_o, 0);
    chk("reset_l2_addr", dif.l2_addr_o, 0);
    chk("reset_rep_en", dif.rep_enable_o, 0);
    chk("reset_rep_word", dif.rep_word_o, 0);
    chk("reset_done", dif.refill_done_o, 0);
    chk("reset_miss_count", dif.miss_count_o, 0);
    chk("reset_lookup", dif.lookup_addr_o, 32'hDEAD_BEEF);
    step();
    rst = 1'b0;

    run_miss(32'h0000_1234, 0, 0,  0, 0, 0, -1, 32'h0000_4000);
    run_miss(32'h0000_1234, 0, 40, 0, 0, 0, -1, 32'h0000_4000);
    run_miss(32'h0000_2A10, 2, 0,  0, 0, 1, -1, 0);
    run_miss(32'h0000_1234, 1, 30, 1, 1, 0, -1, 0);
    run_miss(32'h0000_1234, 0, 0,  0, 0, 0, 3,  0);
    run_miss(32'h0000_1234, 0, 0,  0, 0, 0, -1, 0);
    for (int i = 0; i < 12; i++) begin
      run_miss($urandom, $urandom_range(3), $urandom_range(60), 1'($urandom),
               1'($urandom), ($urandom_range(4) == 0), -1, 0);
    end
    step();
    chk("beats_drained", beat_q.size(), 0);
    chk("lines_drained", line_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_cache_refill_ctrl.md
Name: instr_cache_refill_ctrl

Overview:
Sequences instruction-cache line refills from L2 for the multi-cycle instruction cache set array.
- Detects a fetch miss, latches the block-aligned miss address and issues one L2 line request.
- Streams the returned 64-bit beats into the set array via the replace-enable/replace-word pair.
- Stalls fetch until the line is installed.
- Sits between the fetch stage, the cache set array and the L2 port; also muxes the lookup address so the set sees a stable tag/index for the whole refill.

Parameters:
B, 64, cache block size in bytes; multiple of 8, at least 16.
ADDR_WIDTH, 32, fetch/L2 address width.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
pc_i  in  ADDR_WIDTH  fetch address from fetch stage
fetch_valid_i  in  1  fetch stage requests a lookup this cycle
cache_miss_i  in  1  combined miss from set array for lookup_addr_o
flush_i  in  1  fetch redirect/flush
lookup_addr_o  out  ADDR_WIDTH  address driven to set array tag/index/block inputs
rep_enable_o  out  1  replace enable to set array
rep_word_o  out  64  replace data to set array
stall_o  out  1  hold fetch stage
l2_req_o  out  1  L2 line request
l2_addr_o  out  ADDR_WIDTH  block-aligned L2 request address
l2_ack_i  in  1  L2 accepted request (sampled while l2_req_o=1)
l2_data_valid_i  in  1  L2 beat valid
l2_data_i  in  64  L2 beat data, lowest address first
refill_done_o  out  1  one-cycle pulse, line installed
miss_count_o  out  32  saturating count of refills started

Behaviour:
- Beats per line NB = B/8. Beat counter width is clog2(NB); it wraps to 0 on the last beat.
- Async reset. State=IDLE; counter, miss_count_o and the latched address are 0. All outputs are 0 except lookup_addr_o, which equals pc_i.
- IDLE:
  - lookup_addr_o = pc_i.
  - If fetch_valid_i && cache_miss_i && !flush_i: latch {pc_i[ADDR_WIDTH-1:log2 B], 0s} and go to REQ. miss_count_o increments, saturating at 0xFFFFFFFF.
  - stall_o = fetch_valid_i && cache_miss_i (combinational, same cycle as the miss).
- REQ:
  - l2_req_o=1; l2_addr_o = latched address; lookup_addr_o = latched address; stall_o=1.
  - l2_ack_i=1 -> REFILL. flush_i=1 with l2_ack_i=0 -> IDLE (abort, no L2 transaction). Ack and flush in the same cycle -> REFILL (request committed).
- REFILL:
  - l2_req_o=0; lookup_addr_o and l2_addr_o hold the latched address; stall_o=1.
  - rep_enable_o = l2_data_valid_i; rep_word_o = l2_data_i (combinational pass-through, zero added latency).
  - The counter advances only on valid beats. Gaps are allowed: rep_enable_o is 0 on gap cycles, so the set array's internal counter stalls in step.
  - The valid beat with counter = NB-1 -> DONE.
  - flush_i is ignored in REFILL; the line must complete so set array state stays consistent.
- DONE:
  - One cycle. refill_done_o=1; stall_o=1; lookup_addr_o = latched address, so the set array performs the hit/LRU update; rep_enable_o=0.
  - Next state is IDLE.
- Outside REFILL: rep_enable_o=0, rep_word_o=0, and l2_data_valid_i is ignored.
- Minimum miss penalty with ack in the first REQ cycle and back-to-back beats: miss detected at cycle 0; REQ at cycle 1; REFILL at cycles 2..NB+1; DONE at NB+2; hit in IDLE at NB+3.
- Reset asserted mid-operation: immediate return to IDLE, counters cleared, l2_req_o deasserted. Any outstanding L2 beats are dropped.

Test Plan:
- Reset, then fetch_valid_i=1, pc_i=0x0000_1234, cache_miss_i=1 -> stall_o=1 same cycle; next cycle l2_req_o=1, l2_addr_o=0x0000_1200, miss_count_o=1.
- Ack at first REQ cycle, 8 back-to-back beats 0x..00..07 -> rep_enable_o high exactly 8 cycles, rep_word_o equals each beat, refill_done_o pulses one cycle after the 8th beat, stall_o low the cycle after DONE.
- Beats with gaps (valid pattern 1,0,1,1,0,...) -> rep_enable_o mirrors valid; DONE only after the 8th valid beat.
- flush_i in REQ with no ack -> IDLE next cycle, l2_req_o=0, no rep_enable_o. flush_i during REFILL -> refill completes all 8 beats.
- pc_i changes to 0x0000_4000 during REFILL -> lookup_addr_o and l2_addr_o stay at 0x0000_1200 until IDLE.
- reset_i pulsed asynchronously mid-REFILL after 3 beats -> outputs 0 immediately; a later miss restarts the counter at beat 0.
